// File: rtl/xaddrgen_nd.sv
// ---------------------------------------------------------------------------
// xaddrgen_nd
// Multi-dimensional address generator for one Versat memory port. LEVELS
// nested loops (level 0 innermost), each with its own iteration count and
// signed stride. Supports a start delay and back-to-back restart.
//
// Optional feature macro: XADDRGEN_WRAP_EN
//   When defined, adds wrap_base/wrap_size inputs and folds every newly
//   generated address into [wrap_base, wrap_base+wrap_size) (circular
//   buffers). wrap_size == 0 disables folding.
//
// Ports
//   clk        in   1                  clock
//   rst        in   1                  synchronous active-high reset
//   init       in   1                  load start address, clear counters (IDLE only)
//   run        in   1                  start pulse
//   pause      in   1                  freeze generator, forces mem_en low
//   start      in   MEM_ADDR_W         first address
//   delay      in   CNT_W              cycles between run and first mem_en
//   cnt        in   LEVELS*CNT_W       per-level iteration count (0 behaves as 1)
//   incr       in   LEVELS*MEM_ADDR_W  per-level signed stride
//   wrap_base  in   MEM_ADDR_W         circular window base (XADDRGEN_WRAP_EN only)
//   wrap_size  in   MEM_ADDR_W         circular window size (XADDRGEN_WRAP_EN only)
//   addr       out  MEM_ADDR_W         generated address (registered)
//   mem_en     out  1                  addr valid this cycle
//   done       out  1                  idle / finished
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for run; init loads start and clears counters
// S_DELAY | counting down dly_cnt before the first address
// S_RUN   | one address per unpaused cycle, mem_en high
// ---------------------------------------------------------------------------
module xaddrgen_nd #(
    parameter int MEM_ADDR_W = 16,
    parameter int CNT_W      = 8,
    parameter int LEVELS     = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         init,
    input  logic                         run,
    input  logic                         pause,
    input  logic [MEM_ADDR_W-1:0]        start,
    input  logic [CNT_W-1:0]             delay,
    input  logic [LEVELS*CNT_W-1:0]      cnt,
    input  logic [LEVELS*MEM_ADDR_W-1:0] incr,
`ifdef XADDRGEN_WRAP_EN
    input  logic [MEM_ADDR_W-1:0]        wrap_base,
    input  logic [MEM_ADDR_W-1:0]        wrap_size,
`endif
    output logic [MEM_ADDR_W-1:0]        addr,
    output logic                         mem_en,
    output logic                         done
);

    localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [1:0]            state;
    logic [CNT_W-1:0]      dly_cnt;
    logic [CNT_W-1:0]      it_cnt  [LEVELS];
    logic [MEM_ADDR_W-1:0] base    [LEVELS];

    logic [CNT_W-1:0]      last_it [LEVELS];
    logic [LEVELS-1:0]     at_last;
    logic                  all_last;
    logic                  found;
    logic [LVL_W-1:0]      step_lvl;
    logic [MEM_ADDR_W-1:0] sel_base;
    logic [MEM_ADDR_W-1:0] sel_incr;
    logic [MEM_ADDR_W-1:0] raw_addr;
    logic [MEM_ADDR_W-1:0] new_addr;
`ifdef XADDRGEN_WRAP_EN
    logic [MEM_ADDR_W-1:0] wrap_top;
`endif

    // Terminal counts and the lowest level that still has iterations left.
    always_comb begin
        found    = 1'b0;
        step_lvl = '0;
        sel_base = addr;
        sel_incr = incr[0 +: MEM_ADDR_W];
        for (int l = 0; l < LEVELS; l++) begin
            last_it[l] = (cnt[l*CNT_W +: CNT_W] == '0) ? '0
                         : cnt[l*CNT_W +: CNT_W] - CNT_W'(1);
            at_last[l] = (it_cnt[l] == last_it[l]);
            if (!found && !at_last[l]) begin
                found    = 1'b1;
                step_lvl = LVL_W'(l);
                // Level 0 steps from the current address; outer levels step
                // from their own saved base so inner loops restart cleanly.
                sel_base = (l == 0) ? addr : base[l];
                sel_incr = incr[l*MEM_ADDR_W +: MEM_ADDR_W];
            end
        end
        all_last = &at_last;
        raw_addr = sel_base + sel_incr;
    end

`ifdef XADDRGEN_WRAP_EN
    // Single fold is enough because every |stride| is below wrap_size.
    always_comb begin
        wrap_top = wrap_base + wrap_size;
        if (wrap_size != '0 && raw_addr >= wrap_top)
            new_addr = raw_addr - wrap_size;
        else if (wrap_size != '0 && raw_addr < wrap_base)
            new_addr = raw_addr + wrap_size;
        else
            new_addr = raw_addr;
    end
`else
    always_comb begin
        new_addr = raw_addr;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            addr    <= '0;
            dly_cnt <= '0;
            for (int l = 0; l < LEVELS; l++) begin
                it_cnt[l] <= '0;
                base[l]   <= '0;
            end
        end else if (!pause) begin
            case (state)
                S_IDLE: begin
                    if (init) begin
                        addr <= start;
                        for (int l = 0; l < LEVELS; l++) begin
                            it_cnt[l] <= '0;
                            base[l]   <= start;
                        end
                    end
                    if (run) begin
                        if (delay == '0) begin
                            state <= S_RUN;
                        end else begin
                            state   <= S_DELAY;
                            dly_cnt <= delay;
                        end
                    end
                end
                S_DELAY: begin
                    dly_cnt <= dly_cnt - CNT_W'(1);
                    if (dly_cnt == CNT_W'(1))
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (all_last) begin
                        // Last address: rewind to start either way; run here
                        // keeps us in S_RUN for a bubble-free restart.
                        addr <= start;
                        for (int l = 0; l < LEVELS; l++) begin
                            it_cnt[l] <= '0;
                            base[l]   <= start;
                        end
                        if (!run)
                            state <= S_IDLE;
                    end else begin
                        addr <= new_addr;
                        for (int l = 0; l < LEVELS; l++) begin
                            if (LVL_W'(l) < step_lvl) begin
                                it_cnt[l] <= '0;
                                base[l]   <= new_addr;
                            end else if (LVL_W'(l) == step_lvl) begin
                                it_cnt[l] <= it_cnt[l] + CNT_W'(1);
                                if (l != 0)
                                    base[l] <= new_addr;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_en = (state == S_RUN) && !pause;
    assign done   = (state == S_IDLE);

endmodule

// File: tb/tb_xaddrgen_nd.sv
module tb_xaddrgen_nd;

    localparam int AW = 16;
    localparam int CW = 8;
    localparam int LV = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             init;
    logic             run;
    logic             pause;
    logic [AW-1:0]    start;
    logic [CW-1:0]    delay;
    logic [LV*CW-1:0] cnt;
    logic [LV*AW-1:0] incr;
`ifdef XADDRGEN_WRAP_EN
    logic [AW-1:0]    wrap_base;
    logic [AW-1:0]    wrap_size;
`endif
    logic [AW-1:0]    addr;
    logic             mem_en;
    logic             done;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    xaddrgen_nd #(
        .MEM_ADDR_W (AW),
        .CNT_W      (CW),
        .LEVELS     (LV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .init      (init),
        .run       (run),
        .pause     (pause),
        .start     (start),
        .delay     (delay),
        .cnt       (cnt),
        .incr      (incr),
`ifdef XADDRGEN_WRAP_EN
        .wrap_base (wrap_base),
        .wrap_size (wrap_size),
`endif
        .addr      (addr),
        .mem_en    (mem_en),
        .done      (done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_init;
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    task automatic pulse_run;
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    // Walk the expected address list one cycle per entry. pause_after >= 0
    // inserts a 3-cycle pause right after that index; restart holds run high
    // during the last address.
    task automatic stream(input string tag, input int pause_after, input bit restart);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (pause_after >= 0 && i == pause_after + 1) begin
                pause = 1'b1;
                #1;
                for (int p = 0; p < 3; p++) begin
                    check_val({tag, "_pause_en"}, 32'(mem_en), 32'd0);
                    check_val({tag, "_pause_addr"}, 32'(addr), 32'(exp_q[i]));
                    tick();
                end
                pause = 1'b0;
                #1;
            end
            check_val({tag, "_en"}, 32'(mem_en), 32'd1);
            check_val({tag, "_addr"}, 32'(addr), 32'(exp_q[i]));
            check_val({tag, "_done"}, 32'(done), 32'd0);
            if (restart && i == exp_q.size() - 1)
                run = 1'b1;
            tick();
            run = 1'b0;
        end
    endtask

    task automatic check_idle(input string tag, input logic [AW-1:0] exp_addr);
        check_val({tag, "_end_en"}, 32'(mem_en), 32'd0);
        check_val({tag, "_end_done"}, 32'(done), 32'd1);
        check_val({tag, "_end_addr"}, 32'(addr), 32'(exp_addr));
    endtask

    task automatic cfg_nested;
        start = 16'd0;
        delay = 8'd0;
        cnt   = {8'd2, 8'd3, 8'd4};
        incr  = {16'd100, 16'd10, 16'd1};
        exp_q.delete();
        for (int i2 = 0; i2 < 2; i2++)
            for (int i1 = 0; i1 < 3; i1++)
                for (int i0 = 0; i0 < 4; i0++)
                    exp_q.push_back(100 * i2 + 10 * i1 + i0);
    endtask

    initial begin
        int low;
        int n_en;

        rst   = 1'b1;
        init  = 1'b0;
        run   = 1'b0;
        pause = 1'b0;
        start = '0;
        delay = '0;
        cnt   = '0;
        incr  = '0;
`ifdef XADDRGEN_WRAP_EN
        wrap_base = '0;
        wrap_size = '0;
`endif
        tick();
        tick();
        check_val("rst_addr", 32'(addr), 32'd0);
        check_val("rst_en", 32'(mem_en), 32'd0);
        check_val("rst_done", 32'(done), 32'd1);
        rst = 1'b0;
        tick();

        // Three-level nest, 24 addresses
        cfg_nested();
        do_init();
        check_val("init_addr", 32'(addr), 32'd0);
        pulse_run();
        stream("nest", -1, 1'b0);
        check_idle("nest", 16'd0);

        // Back-to-back restart: 48 addresses, done never rises in between
        pulse_run();
        stream("rst1", -1, 1'b1);
        stream("rst2", -1, 1'b0);
        check_idle("restart", 16'd0);

        // Pause three cycles after address 12 (index 6)
        pulse_run();
        stream("pause", 6, 1'b0);
        check_idle("pause", 16'd0);

        // Start delay with negative stride
        start = 16'd10;
        delay = 8'd5;
        cnt   = {8'd1, 8'd1, 8'd3};
        incr  = {16'd0, 16'd0, 16'hFFFE};
        do_init();
        check_val("dly_init_addr", 32'(addr), 32'd10);
        pulse_run();
        for (int j = 0; j < 5; j++) begin
            check_val("dly_en_low", 32'(mem_en), 32'd0);
            check_val("dly_done_low", 32'(done), 32'd0);
            tick();
        end
        exp_q.delete();
        exp_q.push_back(10);
        exp_q.push_back(8);
        exp_q.push_back(6);
        stream("dly", -1, 1'b0);
        check_idle("dly", 16'd10);

        // All counts zero: a single address; done is low for the two DELAY
        // cycles plus the one address cycle.
        start = 16'd55;
        delay = 8'd2;
        cnt   = '0;
        incr  = {16'd100, 16'd10, 16'd1};
        do_init();
        pulse_run();
        low  = 0;
        n_en = 0;
        for (int j = 0; j < 20 && done == 1'b0; j++) begin
            if (mem_en) begin
                n_en++;
                check_val("zero_addr", 32'(addr), 32'd55);
            end
            low++;
            tick();
        end
        check_val("zero_done_low_cycles", 32'(low), 32'd3);
        check_val("zero_n_addr", 32'(n_en), 32'd1);
        check_idle("zero", 16'd55);

        // Reset in the middle of a sequence
        cfg_nested();
        start = 16'd7;
        do_init();
        pulse_run();
        for (int j = 0; j < 5; j++)
            tick();
        check_val("midrst_pre_en", 32'(mem_en), 32'd1);
        rst = 1'b1;
        tick();
        check_idle("midrst", 16'd0);
        rst = 1'b0;
        tick();
        check_val("midrst_post_en", 32'(mem_en), 32'd0);

`ifdef XADDRGEN_WRAP_EN
        // Circular window [16,24)
        wrap_base = 16'd16;
        wrap_size = 16'd8;
        start     = 16'd22;
        delay     = 8'd0;
        cnt       = {8'd0, 8'd0, 8'd5};
        incr      = {16'd0, 16'd0, 16'd1};
        exp_q.delete();
        exp_q.push_back(22);
        exp_q.push_back(23);
        exp_q.push_back(16);
        exp_q.push_back(17);
        exp_q.push_back(18);
        do_init();
        pulse_run();
        stream("wrap", -1, 1'b0);
        check_idle("wrap", 16'd22);
        wrap_size = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
